// File: rtl/axi4lite_pkg.sv
// Shared definitions for the AXI4-Lite SRAM responder: response codes and
// the read/write channel state encodings.
package axi4lite_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {
        R_IDLE = 2'd0,
        R_WAIT = 2'd1,
        R_RESP = 2'd2
    } rd_state_t;

    typedef enum logic [1:0] {
        W_IDLE = 2'd0,
        W_WAIT = 2'd1,
        W_RESP = 2'd2
    } wr_state_t;

endpackage

// File: rtl/axi4lite_lat_ctr.sv
// Load/decrement latency counter with a zero flag, one per channel.
// With AXI4LITE_SRAM_RAND_DELAY_EN defined, each load adds 0..3 extra cycles from an LFSR.
module axi4lite_lat_ctr #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic             zero
);

    logic [WIDTH-1:0] count;
    logic [WIDTH-1:0] extra;

`ifdef AXI4LITE_SRAM_RAND_DELAY_EN
    logic [7:0] lfsr;

    // Fibonacci LFSR, taps 8,6,5,4, free-running so the jitter is uncorrelated with traffic
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lfsr <= 8'hA5;
        end else begin
            lfsr <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
        end
    end

    assign extra = WIDTH'(lfsr[1:0]);
`else
    assign extra = '0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (load) begin
            count <= load_val + extra;
        end else if (count != '0) begin
            count <= count - 1'b1;
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/axi4lite_sram_slave.sv
// AXI4-Lite responder fronting word-addressed on-chip SRAM with independent
// read/write latency counters. Optional macro: AXI4LITE_SRAM_RAND_DELAY_EN.
module axi4lite_sram_slave
    import axi4lite_pkg::*;
#(
    parameter int                    ADDR_WIDTH = 32,
    parameter int                    DATA_WIDTH = 32,
    parameter int                    DEPTH_LOG2 = 10,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = 32'h8000_0000,
    parameter int                    RD_LAT     = 2,
    parameter int                    WR_LAT     = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  arvalid,
    input  logic [ADDR_WIDTH-1:0] araddr,
    output logic                  arready,
    output logic                  rvalid,
    output logic [DATA_WIDTH-1:0] rdata,
    output logic [1:0]            rresp,
    input  logic                  rready,
    input  logic                  awvalid,
    input  logic [ADDR_WIDTH-1:0] awaddr,
    output logic                  awready,
    input  logic                  wvalid,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic [3:0]            wstrb,
    output logic                  wready,
    output logic                  bvalid,
    output logic [1:0]            bresp,
    input  logic                  bready
);

    localparam int                    DEPTH = 1 << DEPTH_LOG2;
    localparam int                    CTR_W = 8;
    localparam logic [ADDR_WIDTH-1:0] SPAN  = ADDR_WIDTH'(64'd4 << DEPTH_LOG2);

    logic [DATA_WIDTH-1:0] mem [0:DEPTH-1];

    rd_state_t             rd_state, rd_next;
    logic                  rd_load, rd_zero, rd_hit;
    logic [ADDR_WIDTH-1:0] ar_addr, rd_off;
    logic [DEPTH_LOG2-1:0] rd_idx;

    wr_state_t             wr_state, wr_next;
    logic                  wr_load, wr_zero, wr_hit, wr_commit;
    logic                  aw_cap, w_cap;
    logic [ADDR_WIDTH-1:0] aw_addr, wr_off;
    logic [DEPTH_LOG2-1:0] wr_idx;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic [3:0]            wstrb_q;

    // Unsigned wrap-around makes addresses below BASE_ADDR decode as out of range
    assign rd_off = ar_addr - BASE_ADDR;
    assign rd_hit = rd_off < SPAN;
    assign rd_idx = rd_off[DEPTH_LOG2+1:2];
    assign wr_off = aw_addr - BASE_ADDR;
    assign wr_hit = wr_off < SPAN;
    assign wr_idx = wr_off[DEPTH_LOG2+1:2];

    axi4lite_lat_ctr #(.WIDTH(CTR_W)) u_rd_ctr (
        .clk      (clk),
        .rst      (rst),
        .load     (rd_load),
        .load_val (CTR_W'(RD_LAT - 1)),
        .zero     (rd_zero)
    );

    axi4lite_lat_ctr #(.WIDTH(CTR_W)) u_wr_ctr (
        .clk      (clk),
        .rst      (rst),
        .load     (wr_load),
        .load_val (CTR_W'(WR_LAT - 1)),
        .zero     (wr_zero)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_state <= R_IDLE;
            wr_state <= W_IDLE;
        end else begin
            rd_state <= rd_next;
            wr_state <= wr_next;
        end
    end

    always_comb begin
        rd_next = rd_state;
        arready = 1'b0;
        rd_load = 1'b0;
        case (rd_state)
            R_IDLE: begin
                arready = 1'b1;
                if (arvalid) begin
                    rd_load = 1'b1;
                    rd_next = R_WAIT;
                end
            end
            R_WAIT:  if (rd_zero) rd_next = R_RESP;
            R_RESP:  if (rready) rd_next = R_IDLE;
            default: rd_next = R_IDLE;
        endcase
    end

    assign rvalid = (rd_state == R_RESP);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ar_addr <= '0;
            rdata   <= '0;
            rresp   <= RESP_OKAY;
        end else begin
            if (rd_load) ar_addr <= araddr;
            if (rd_state == R_WAIT && rd_zero) begin
                rdata <= rd_hit ? mem[rd_idx] : '0;
                rresp <= rd_hit ? RESP_OKAY : RESP_SLVERR;
            end
        end
    end

    // AW and W are latched independently; the counter starts on the edge that completes the pair
    always_comb begin
        wr_next = wr_state;
        awready = 1'b0;
        wready  = 1'b0;
        wr_load = 1'b0;
        case (wr_state)
            W_IDLE: begin
                awready = !aw_cap;
                wready  = !w_cap;
                if ((aw_cap || awvalid) && (w_cap || wvalid)) begin
                    wr_load = 1'b1;
                    wr_next = W_WAIT;
                end
            end
            W_WAIT:  if (wr_zero) wr_next = W_RESP;
            W_RESP:  if (bready) wr_next = W_IDLE;
            default: wr_next = W_IDLE;
        endcase
    end

    assign bvalid    = (wr_state == W_RESP);
    assign wr_commit = (wr_state == W_WAIT) && wr_zero;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            aw_cap  <= 1'b0;
            w_cap   <= 1'b0;
            aw_addr <= '0;
            wdata_q <= '0;
            wstrb_q <= '0;
            bresp   <= RESP_OKAY;
        end else begin
            if (wr_state == W_RESP && bready) begin
                aw_cap <= 1'b0;
                w_cap  <= 1'b0;
            end else begin
                if (awvalid && awready) begin
                    aw_cap  <= 1'b1;
                    aw_addr <= awaddr;
                end
                if (wvalid && wready) begin
                    w_cap   <= 1'b1;
                    wdata_q <= wdata;
                    wstrb_q <= wstrb;
                end
            end
            if (wr_commit) bresp <= wr_hit ? RESP_OKAY : RESP_SLVERR;
        end
    end

    // Non-blocking write means a read sampling the same word on this edge sees the old data
    always_ff @(posedge clk) begin
        if (wr_commit && wr_hit) begin
            for (int i = 0; i < 4; i++) begin
                if (wstrb_q[i]) mem[wr_idx][8*i +: 8] <= wdata_q[8*i +: 8];
            end
        end
    end

endmodule
